// File: rtl/ex_m_pipe_reg.sv
// ============================================================================
// ex_m_pipe_reg : EX->M pipeline register with stall/flush, store lane
//                 alignment, forwarding tap and saturating perf counters.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ex_m_pipe_reg #(
    parameter int PC_SIZE    = 18,
    parameter int DATA_SIZE  = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    M_Stall,
    input  logic                    M_Flush,
    input  logic                    EX_Valid,
    input  logic                    EX_MemtoReg,
    input  logic                    EX_RegWrite,
    input  logic                    EX_MemWrite,
    input  logic                    EX_Jal,
    input  logic                    EX_SignextendLoad,
    input  logic                    EX_Signextend,
    input  logic [1:0]              EX_MemSize,
    input  logic [DATA_SIZE-1:0]    EX_ALU_result,
    input  logic [DATA_SIZE-1:0]    EX_Rt_data,
    input  logic [PC_SIZE-1:0]      EX_PCplus8,
    input  logic [REG_ADDR_W-1:0]   EX_WR_out,
    output logic                    M_Valid,
    output logic                    M_MemtoReg,
    output logic                    M_RegWrite,
    output logic                    M_MemWrite,
    output logic                    M_Jal,
    output logic                    M_SignextendLoad,
    output logic                    M_Signextend,
    output logic [1:0]              M_MemSize,
    output logic [DATA_SIZE-1:0]    M_ALU_result,
    output logic [DATA_SIZE-1:0]    M_Rt_data,
    output logic [DATA_SIZE/8-1:0]  M_ByteEn,
    output logic                    M_Misaligned,
    output logic [PC_SIZE-1:0]      M_PCplus8,
    output logic [REG_ADDR_W-1:0]   M_WR_out,
    output logic                    M_Fwd_en,
    output logic [DATA_SIZE-1:0]    M_Fwd_data,
    output logic                    M_LoadPending,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    localparam int c_be_w  = DATA_SIZE / 8;
    localparam int c_off_w = $clog2(c_be_w);

    logic                  valid_q, valid_d;
    logic                  memtoreg_q, memtoreg_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memwrite_q, memwrite_d;
    logic                  jal_q, jal_d;
    logic                  sxload_q, sxload_d;
    logic                  sx_q, sx_d;
    logic [1:0]            memsize_q, memsize_d;
    logic [DATA_SIZE-1:0]  alu_q, alu_d;
    logic [DATA_SIZE-1:0]  rt_q, rt_d;
    logic [PC_SIZE-1:0]    pc8_q, pc8_d;
    logic [REG_ADDR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        valid_d      = valid_q;
        memtoreg_d   = memtoreg_q;
        regwrite_d   = regwrite_q;
        memwrite_d   = memwrite_q;
        jal_d        = jal_q;
        sxload_d     = sxload_q;
        sx_d         = sx_q;
        memsize_d    = memsize_q;
        alu_d        = alu_q;
        rt_d         = rt_q;
        pc8_d        = pc8_q;
        wr_d         = wr_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (M_Flush) begin
            // Bubble: kill the instruction's side effects, leave data fields alone
            valid_d    = 1'b0;
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
            memwrite_d = 1'b0;
            jal_d      = 1'b0;
            sxload_d   = 1'b0;
            sx_d       = 1'b0;
            memsize_d  = 2'd0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end else if (M_Stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        end else begin
            valid_d    = EX_Valid;
            memtoreg_d = EX_MemtoReg;
            regwrite_d = EX_RegWrite;
            memwrite_d = EX_MemWrite;
            jal_d      = EX_Jal;
            sxload_d   = EX_SignextendLoad;
            sx_d       = EX_Signextend;
            memsize_d  = EX_MemSize;
            alu_d      = EX_ALU_result;
            rt_d       = EX_Rt_data;
            pc8_d      = EX_PCplus8;
            wr_d       = EX_WR_out;
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            memwrite_q   <= 1'b0;
            jal_q        <= 1'b0;
            sxload_q     <= 1'b0;
            sx_q         <= 1'b0;
            memsize_q    <= 2'd0;
            alu_q        <= '0;
            rt_q         <= '0;
            pc8_q        <= '0;
            wr_q         <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            memwrite_q   <= memwrite_d;
            jal_q        <= jal_d;
            sxload_q     <= sxload_d;
            sx_q         <= sx_d;
            memsize_q    <= memsize_d;
            alu_q        <= alu_d;
            rt_q         <= rt_d;
            pc8_q        <= pc8_d;
            wr_q         <= wr_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    logic [c_off_w-1:0]   w_off;
    logic [3:0]           w_sz;
    logic [c_off_w-1:0]   w_sz_lo;
    logic                 w_oversize;
    logic                 w_misal;
    logic                 w_mem_access;
    logic                 w_misaligned;
    logic [15:0]          w_lane_mask;
    logic [15:0]          w_be_full;
    logic [DATA_SIZE-1:0] w_rt_rep;

    always_comb begin
        w_off        = alu_q[c_off_w-1:0];
        w_sz         = 4'd1 << memsize_q;
        w_sz_lo      = w_sz[c_off_w-1:0];
        w_oversize   = int'(w_sz) > c_be_w;
        // sz is a power of two, so off mod sz is just the low bits of off
        w_misal      = (w_off & (w_sz_lo - c_off_w'(1))) != '0;
        w_mem_access = valid_q & (memwrite_q | memtoreg_q);
        w_misaligned = w_mem_access & (w_oversize | w_misal);
        w_lane_mask  = (16'd1 << w_sz) - 16'd1;
        w_be_full    = (w_mem_access && !w_misaligned) ? (w_lane_mask << w_off) : 16'd0;
        w_rt_rep     = '0;
        for (int i = 0; i < c_be_w; i++) begin
            case (memsize_q)
                2'd0:    w_rt_rep[8*i +: 8] = rt_q[7:0];
                2'd1:    w_rt_rep[8*i +: 8] = rt_q[8*(i%2) +: 8];
                2'd2:    w_rt_rep[8*i +: 8] = rt_q[8*(i%4) +: 8];
                default: w_rt_rep[8*i +: 8] = rt_q[8*(i%8) +: 8];
            endcase
        end
    end

    assign M_Valid          = valid_q;
    assign M_MemtoReg       = memtoreg_q & valid_q;
    assign M_RegWrite       = regwrite_q & valid_q;
    assign M_MemWrite       = memwrite_q & valid_q & ~w_misaligned;
    assign M_Jal            = jal_q & valid_q;
    assign M_SignextendLoad = sxload_q & valid_q;
    assign M_Signextend     = sx_q & valid_q;
    assign M_MemSize        = memsize_q;
    assign M_ALU_result     = alu_q;
    assign M_Rt_data        = w_rt_rep;
    assign M_ByteEn         = w_be_full[c_be_w-1:0];
    assign M_Misaligned     = w_misaligned;
    assign M_PCplus8        = pc8_q;
    assign M_WR_out         = wr_q;
    assign M_Fwd_en         = valid_q & regwrite_q & ~memtoreg_q & (wr_q != '0);
    assign M_Fwd_data       = jal_q ? DATA_SIZE'(pc8_q) : alu_q;
    assign M_LoadPending    = valid_q & regwrite_q & memtoreg_q & (wr_q != '0);
    assign stall_cnt        = stall_cnt_q;
    assign bubble_cnt       = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_m_pipe_reg.sv
// ============================================================================
// tb_ex_m_pipe_reg : directed self-checking bench for ex_m_pipe_reg (CNT_W=4).
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_ex_m_pipe_reg;

    logic        clk;
    logic        rst;
    logic        M_Stall, M_Flush, EX_Valid;
    logic        EX_MemtoReg, EX_RegWrite, EX_MemWrite, EX_Jal;
    logic        EX_SignextendLoad, EX_Signextend;
    logic [1:0]  EX_MemSize;
    logic [31:0] EX_ALU_result, EX_Rt_data;
    logic [17:0] EX_PCplus8;
    logic [4:0]  EX_WR_out;
    logic        M_Valid, M_MemtoReg, M_RegWrite, M_MemWrite, M_Jal;
    logic        M_SignextendLoad, M_Signextend;
    logic [1:0]  M_MemSize;
    logic [31:0] M_ALU_result, M_Rt_data;
    logic [3:0]  M_ByteEn;
    logic        M_Misaligned;
    logic [17:0] M_PCplus8;
    logic [4:0]  M_WR_out;
    logic        M_Fwd_en;
    logic [31:0] M_Fwd_data;
    logic        M_LoadPending;
    logic [3:0]  stall_cnt, bubble_cnt;

    int checks = 0;
    int passed = 0;

    ex_m_pipe_reg #(.PC_SIZE(18), .DATA_SIZE(32), .REG_ADDR_W(5), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .M_Stall(M_Stall), .M_Flush(M_Flush), .EX_Valid(EX_Valid),
        .EX_MemtoReg(EX_MemtoReg), .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite),
        .EX_Jal(EX_Jal), .EX_SignextendLoad(EX_SignextendLoad), .EX_Signextend(EX_Signextend),
        .EX_MemSize(EX_MemSize), .EX_ALU_result(EX_ALU_result), .EX_Rt_data(EX_Rt_data),
        .EX_PCplus8(EX_PCplus8), .EX_WR_out(EX_WR_out),
        .M_Valid(M_Valid), .M_MemtoReg(M_MemtoReg), .M_RegWrite(M_RegWrite),
        .M_MemWrite(M_MemWrite), .M_Jal(M_Jal), .M_SignextendLoad(M_SignextendLoad),
        .M_Signextend(M_Signextend), .M_MemSize(M_MemSize), .M_ALU_result(M_ALU_result),
        .M_Rt_data(M_Rt_data), .M_ByteEn(M_ByteEn), .M_Misaligned(M_Misaligned),
        .M_PCplus8(M_PCplus8), .M_WR_out(M_WR_out), .M_Fwd_en(M_Fwd_en),
        .M_Fwd_data(M_Fwd_data), .M_LoadPending(M_LoadPending),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        M_Stall = 0; M_Flush = 0; EX_Valid = 0;
        EX_MemtoReg = 0; EX_RegWrite = 0; EX_MemWrite = 0; EX_Jal = 0;
        EX_SignextendLoad = 0; EX_Signextend = 0; EX_MemSize = 2'd0;
        EX_ALU_result = 32'h0; EX_Rt_data = 32'h0; EX_PCplus8 = 18'h0; EX_WR_out = 5'd0;
    endtask

    // State updates happen on the falling edge; sample 1 time unit later.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        EX_Valid = 1; EX_RegWrite = 1; EX_ALU_result = 32'h77; EX_WR_out = 5'd3;
        rst = 0;
        tick();
        checks++; if (M_Valid !== 1'b1) $display("FAIL reset_pre_valid got=%b exp=1", M_Valid); else passed++;
        @(posedge clk);
        #1 rst = 1;
        #1;
        checks++; if (M_Valid !== 1'b0) $display("FAIL reset_async_valid got=%b exp=0", M_Valid); else passed++;
        checks++; if (M_Fwd_en !== 1'b0 || M_Fwd_data !== 32'h0) $display("FAIL reset_async_fwd got=%b/%h exp=0/0", M_Fwd_en, M_Fwd_data); else passed++;
        checks++; if (M_ALU_result !== 32'h0 || M_WR_out !== 5'd0 || M_ByteEn !== 4'h0) $display("FAIL reset_async_fields got=%h/%h/%h exp=0", M_ALU_result, M_WR_out, M_ByteEn); else passed++;
        checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); else passed++;
        #1 rst = 0;
        clear_inputs();
    endtask

    task automatic test_load();
        clear_inputs();
        EX_Valid = 1; EX_RegWrite = 1; EX_ALU_result = 32'h0000_1234; EX_WR_out = 5'd8;
        tick();
        checks++; if (M_Fwd_en !== 1'b1) $display("FAIL load_fwd_en got=%b exp=1", M_Fwd_en); else passed++;
        checks++; if (M_Fwd_data !== 32'h1234) $display("FAIL load_fwd_data got=%h exp=00001234", M_Fwd_data); else passed++;
        checks++; if (M_RegWrite !== 1'b1 || M_Valid !== 1'b1 || M_WR_out !== 5'd8) $display("FAIL load_ctrl got=%b/%b/%0d exp=1/1/8", M_RegWrite, M_Valid, M_WR_out); else passed++;
    endtask

    task automatic test_stall_flush();
        M_Stall = 1;
        for (int i = 0; i < 3; i++) begin
            EX_ALU_result = 32'hDEAD_0000 + i;
            EX_WR_out     = 5'(i + 12);
            EX_Valid      = i[0];
            tick();
        end
        checks++; if (M_Fwd_data !== 32'h1234 || M_WR_out !== 5'd8 || M_Valid !== 1'b1) $display("FAIL stall_hold got=%h/%0d/%b exp=00001234/8/1", M_Fwd_data, M_WR_out, M_Valid); else passed++;
        checks++; if (stall_cnt !== 4'd3) $display("FAIL stall_cnt got=%0d exp=3", stall_cnt); else passed++;
        M_Flush = 1;
        tick();
        checks++; if (M_Valid !== 1'b0 || M_RegWrite !== 1'b0 || M_Fwd_en !== 1'b0) $display("FAIL flush_bubble got=%b/%b/%b exp=0/0/0", M_Valid, M_RegWrite, M_Fwd_en); else passed++;
        checks++; if (bubble_cnt !== 4'd1 || stall_cnt !== 4'd3) $display("FAIL flush_counters got=%0d/%0d exp=1/3", bubble_cnt, stall_cnt); else passed++;
        checks++; if (M_ALU_result !== 32'h1234) $display("FAIL flush_data_hold got=%h exp=00001234", M_ALU_result); else passed++;
        clear_inputs();
    endtask

    task automatic test_store_lanes();
        clear_inputs();
        EX_Valid = 1; EX_MemWrite = 1; EX_MemSize = 2'd1; EX_ALU_result = 32'h2; EX_Rt_data = 32'hAABB_CCDD;
        tick();
        checks++; if (M_ByteEn !== 4'b1100 || M_Rt_data !== 32'hCCDD_CCDD) $display("FAIL store_half got=%b/%h exp=1100/ccddccdd", M_ByteEn, M_Rt_data); else passed++;
        checks++; if (M_MemWrite !== 1'b1 || M_Misaligned !== 1'b0) $display("FAIL store_half_we got=%b/%b exp=1/0", M_MemWrite, M_Misaligned); else passed++;
        EX_ALU_result = 32'h3;
        tick();
        checks++; if (M_Misaligned !== 1'b1 || M_ByteEn !== 4'b0000 || M_MemWrite !== 1'b0) $display("FAIL store_half_misal got=%b/%b/%b exp=1/0000/0", M_Misaligned, M_ByteEn, M_MemWrite); else passed++;
        EX_MemSize = 2'd0; EX_ALU_result = 32'h1;
        tick();
        checks++; if (M_ByteEn !== 4'b0010 || M_Rt_data !== 32'hDDDD_DDDD || M_Misaligned !== 1'b0) $display("FAIL store_byte got=%b/%h/%b exp=0010/dddddddd/0", M_ByteEn, M_Rt_data, M_Misaligned); else passed++;
        EX_MemSize = 2'd2; EX_ALU_result = 32'h100;
        tick();
        checks++; if (M_ByteEn !== 4'b1111 || M_Rt_data !== 32'hAABB_CCDD) $display("FAIL store_word got=%b/%h exp=1111/aabbccdd", M_ByteEn, M_Rt_data); else passed++;
        EX_ALU_result = 32'h102;
        tick();
        checks++; if (M_Misaligned !== 1'b1 || M_ByteEn !== 4'b0000) $display("FAIL store_word_misal got=%b/%b exp=1/0000", M_Misaligned, M_ByteEn); else passed++;
        EX_MemSize = 2'd3; EX_ALU_result = 32'h0;
        tick();
        checks++; if (M_Misaligned !== 1'b1 || M_MemWrite !== 1'b0 || M_ByteEn !== 4'b0000) $display("FAIL store_oversize got=%b/%b/%b exp=1/0/0000", M_Misaligned, M_MemWrite, M_ByteEn); else passed++;
        EX_MemWrite = 0; EX_MemSize = 2'd2; EX_ALU_result = 32'h1;
        tick();
        checks++; if (M_Misaligned !== 1'b0 || M_ByteEn !== 4'b0000) $display("FAIL non_mem_access got=%b/%b exp=0/0000", M_Misaligned, M_ByteEn); else passed++;
        clear_inputs();
    endtask

    task automatic test_jal_load();
        clear_inputs();
        EX_Valid = 1; EX_RegWrite = 1; EX_Jal = 1; EX_PCplus8 = 18'h0_0108; EX_WR_out = 5'd31; EX_ALU_result = 32'h5555;
        tick();
        checks++; if (M_Fwd_data !== 32'h108 || M_Fwd_en !== 1'b1 || M_Jal !== 1'b1) $display("FAIL jal_fwd got=%h/%b/%b exp=00000108/1/1", M_Fwd_data, M_Fwd_en, M_Jal); else passed++;
        EX_Jal = 0; EX_MemtoReg = 1; EX_MemSize = 2'd2; EX_ALU_result = 32'h100; EX_WR_out = 5'd4;
        tick();
        checks++; if (M_LoadPending !== 1'b1 || M_Fwd_en !== 1'b0) $display("FAIL load_pending got=%b/%b exp=1/0", M_LoadPending, M_Fwd_en); else passed++;
        checks++; if (M_ByteEn !== 4'b1111 || M_MemWrite !== 1'b0) $display("FAIL load_byteen got=%b/%b exp=1111/0", M_ByteEn, M_MemWrite); else passed++;
        EX_WR_out = 5'd0;
        tick();
        checks++; if (M_LoadPending !== 1'b0) $display("FAIL load_r0 got=%b exp=0", M_LoadPending); else passed++;
        EX_MemtoReg = 0; EX_Valid = 0; EX_WR_out = 5'd9; EX_Signextend = 1;
        tick();
        checks++; if (M_RegWrite !== 1'b0 || M_Fwd_en !== 1'b0 || M_Signextend !== 1'b0) $display("FAIL invalid_gate got=%b/%b/%b exp=0/0/0", M_RegWrite, M_Fwd_en, M_Signextend); else passed++;
        clear_inputs();
    endtask

    task automatic test_saturation();
        clear_inputs();
        #1 rst = 1;
        #1 rst = 0;
        M_Stall = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (stall_cnt !== 4'd15) $display("FAIL sat_reach got=%0d exp=15", stall_cnt); else passed++;
            end
        end
        checks++; if (stall_cnt !== 4'd15) $display("FAIL sat_hold got=%0d exp=15", stall_cnt); else passed++;
        @(posedge clk);
        #1 rst = 1;
        #1;
        checks++; if (stall_cnt !== 4'd0) $display("FAIL reset_mid_stall got=%0d exp=0", stall_cnt); else passed++;
        rst = 0;
        tick();
        checks++; if (stall_cnt !== 4'd1) $display("FAIL restart_cnt got=%0d exp=1", stall_cnt); else passed++;
        M_Stall = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        test_reset();
        test_load();
        test_stall_flush();
        test_store_lanes();
        test_jal_load();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
